// File: rtl/recon_113_pkg.sv
// recon_113_pkg: shared constants, state encoding and a chunk-select helper
// for the divide-by-113 dividend reconstruction block.
package recon_113_pkg;

  localparam int DIVISOR = 113;
  localparam int Q_W     = 30;
  localparam int R_W     = 7;
  localparam int X_W     = 36;
  localparam int ACC_W   = 37;
  localparam int CHUNK_W = 6;
  localparam int NCHUNK  = 5;
  localparam int PROD_W  = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Select the 6-bit chunk of q for a given step, MSB chunk first.
  function automatic logic [CHUNK_W-1:0] get_chunk(input logic [Q_W-1:0] qv,
                                                   input logic [2:0]     idx);
    logic [CHUNK_W-1:0] c;
    case (idx)
      3'd0:    c = qv[29:24];
      3'd1:    c = qv[23:18];
      3'd2:    c = qv[17:12];
      3'd3:    c = qv[11:6];
      3'd4:    c = qv[5:0];
      default: c = 6'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/recon_113_mul.sv
// mul113_chunk: combinational 6-bit x 113 multiply built from shifts and adds
// (113 = 64 + 32 + 16 + 1).
//   c : 6-bit chunk input
//   p : 13-bit product c*113
module mul113_chunk
  import recon_113_pkg::*;
(
  input  logic [CHUNK_W-1:0] c,
  output logic [PROD_W-1:0]  p
);

  logic [PROD_W-1:0] c_ext_s;

  assign c_ext_s = {7'd0, c};
  assign p = (c_ext_s << 6) + (c_ext_s << 5) + (c_ext_s << 4) + c_ext_s;

endmodule

// File: rtl/recon_113.sv
// recon_113: rebuilds a 36-bit dividend from a divide-by-113 quotient and
// remainder, x = (q*113 + r) mod 2^36, over five multiply cycles.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake carrying q (30b) and r (7b)
//   out_valid/out_ready : result handshake carrying x (36b) and err
//   err                 : r > 112, or the 37-bit sum reached 2^36
module recon_113
  import recon_113_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Q_W-1:0] q,
  input  logic [R_W-1:0] r,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [X_W-1:0] x,
  output logic           err
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [Q_W-1:0]     q_q, q_d;
  logic [R_W-1:0]     r_q, r_d;
  logic [2:0]         idx_q, idx_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [CHUNK_W-1:0] chunk_s;
  logic [PROD_W-1:0]  prod_s;

  assign chunk_s = get_chunk(q_q, idx_q);

  mul113_chunk u_mul (
    .c (chunk_s),
    .p (prod_s)
  );

  // Next-state, accumulator and handshake-output computation.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    r_d     = r_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          q_d     = q;
          r_d     = r;
          acc_d   = '0;
          idx_d   = 3'd0;
          state_d = MUL;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        // The remainder joins the sum together with the last (LSB) chunk.
        if (idx_q == 3'(NCHUNK - 1)) begin
          acc_d   = (acc_q << CHUNK_W) + ACC_W'(prod_s) + ACC_W'(r_q);
          idx_d   = 3'd0;
          state_d = DONE;
        end else begin
          acc_d   = (acc_q << CHUNK_W) + ACC_W'(prod_s);
          idx_d   = idx_q + 3'd1;
          state_d = MUL;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake outputs are registered copies of the upcoming state, so
    // in_ready stays low during reset and rises on the first edge after it.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State, operand, accumulator and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      idx_q       <= 3'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      q_q         <= q_d;
      r_q         <= r_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x         = acc_q[X_W-1:0];
  assign err       = acc_q[ACC_W-1] | (r_q > 7'(DIVISOR - 1));

endmodule

// File: tb/tb_recon_113.sv
module tb_recon_113;

  typedef struct {
    logic [35:0] x;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [29:0] q = 30'd0;
  logic [6:0]  r = 7'd0;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] x;
  logic        err;

  logic        man_rdy = 1'b1;
  logic        rnd_bit = 1'b1;
  logic        rand_mode = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  assign out_ready = rand_mode ? rnd_bit : man_rdy;

  recon_113 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain full-width arithmetic.
  function automatic exp_t model(input logic [29:0] qv, input logic [6:0] rv);
    logic [36:0] full;
    exp_t e;
    full  = 37'(qv) * 37'd113 + 37'(rv);
    e.x   = full[35:0];
    e.err = full[36] | (rv > 7'd112);
    e.cyc = 0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for in_ready, issue one operand, push its expectation.
  task automatic send(input logic [29:0] qv, input logic [6:0] rv);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed %0b expected 1", in_ready);
    end else begin
      q = qv;
      r = rv;
      in_valid = 1'b1;
      e = model(qv, rv);
      e.cyc = cyc + 6;
      sb.push_back(e);
      tick();
      in_valid = 1'b0;
    end
  endtask

  // Monitor: pops on the first cycle of each result, then checks stability.
  initial begin
    exp_t cur;
    bit   active;
    bit   prev_acc;
    active = 1'b0;
    prev_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        prev_acc = 1'b0;
      end else begin
        if (prev_acc) begin
          chk("in_ready_after_accept", {63'd0, in_ready}, 64'd1);
          chk("out_valid_after_accept", {63'd0, out_valid}, 64'd0);
        end
        prev_acc = 1'b0;
        if (out_valid) begin
          if (!active) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_out: out_valid=1 x=%0h with no pending operand", x);
            end else begin
              cur = sb.pop_front();
              active = 1'b1;
              chk("latency", 64'(cyc), 64'(cur.cyc));
            end
          end
          if (active) begin
            chk("x", {28'd0, x}, {28'd0, cur.x});
            chk("err", {63'd0, err}, {63'd0, cur.err});
            chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
          end
          if (out_ready) begin
            active = 1'b0;
            prev_acc = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int n;
    // Reset state
    tick();
    tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_x", {28'd0, x}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("in_ready_first_edge", {63'd0, in_ready}, 64'd1);

    // Directed vectors
    send(30'd0, 7'd0);
    send(30'd1, 7'd112);
    send(30'd608136962, 7'd29);
    send(30'd608136962, 7'd30);
    send(30'd5, 7'd113);

    // Hold out_ready low four cycles in DONE, with ignored in_valid pulses
    send(30'd7, 7'd3);
    man_rdy = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("hold_reached_done", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      q = 30'h2AAAAAAA;
      r = 7'd9;
      tick();
    end
    in_valid = 1'b0;
    man_rdy = 1'b1;
    tick();
    tick();

    // Reset pulse during MUL cycle 3 aborts the operand
    send(30'd12345, 7'd1);
    tick();
    tick();
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
    end
    send(30'd2, 7'd7);

    // Random back-to-back operands with random out_ready
    rand_mode = 1'b1;
    for (int i = 0; i < 25; i++) begin
      send(30'($urandom), 7'($urandom_range(0, 127)));
    end

    // Drain
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    rand_mode = 1'b0;
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
